// File: rtl/instruction_decode.sv
// LEGv8 decode stage: classifies the instruction, drives datapath controls and the
// sign-extended immediate, reads the 32x64 register file and resolves B/CBZ/CBNZ.
module instruction_decode (
  input  logic [31:0] Instruction,
  input  logic [63:0] PC,
  output logic        PCSrc,
  output logic [63:0] BranchAddress,
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        RegWriteIn,
  input  logic [4:0]  WriteReg,
  input  logic [63:0] WriteData,
  output logic [63:0] ReadData1,
  output logic [63:0] ReadData2,
  output logic [63:0] SignExtImm,
  output logic        Reg2Loc,
  output logic        ALUSrc,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        Branch,
  output logic [1:0]  ALUOp
);

  typedef enum logic [2:0] {
    I_NONE, I_RTYPE, I_IMM, I_LDUR, I_STUR, I_B, I_CBZ, I_CBNZ
  } iclass_t;

  iclass_t     iclass;
  logic [10:0] opc;
  logic [63:0] regs [0:31];
  logic [4:0]  rn;
  logic [4:0]  rsel2;
  logic        taken;

  assign opc = Instruction[31:21];

  // HALT (all ones) matches none of the patterns and falls through to I_NONE.
  always_comb begin
    iclass = I_NONE;
    if (opc inside {11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000})
      iclass = I_RTYPE;
    else if (opc[10:1] inside {10'b1001000100, 10'b1101000100})
      iclass = I_IMM;
    else if (opc == 11'b11111000010)
      iclass = I_LDUR;
    else if (opc == 11'b11111000000)
      iclass = I_STUR;
    else if (opc[10:5] == 6'b000101)
      iclass = I_B;
    else if (opc[10:3] == 8'b10110100)
      iclass = I_CBZ;
    else if (opc[10:3] == 8'b10110101)
      iclass = I_CBNZ;
  end

  always_comb begin
    Reg2Loc    = 1'b0;
    ALUSrc     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    Branch     = 1'b0;
    ALUOp      = 2'b00;
    SignExtImm = '0;
    unique case (iclass)
      I_RTYPE: begin
        RegWrite = 1'b1;
        ALUOp    = 2'b10;
      end
      I_IMM: begin
        RegWrite   = 1'b1;
        ALUSrc     = 1'b1;
        ALUOp      = 2'b10;
        SignExtImm = {52'd0, Instruction[21:10]};
      end
      I_LDUR: begin
        ALUSrc     = 1'b1;
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        MemRead    = 1'b1;
        SignExtImm = {{55{Instruction[20]}}, Instruction[20:12]};
      end
      I_STUR: begin
        Reg2Loc    = 1'b1;
        ALUSrc     = 1'b1;
        MemWrite   = 1'b1;
        SignExtImm = {{55{Instruction[20]}}, Instruction[20:12]};
      end
      I_B: begin
        Branch     = 1'b1;
        SignExtImm = {{38{Instruction[25]}}, Instruction[25:0]};
      end
      I_CBZ, I_CBNZ: begin
        Reg2Loc    = 1'b1;
        Branch     = 1'b1;
        ALUOp      = 2'b01;
        SignExtImm = {{45{Instruction[23]}}, Instruction[23:5]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned i = 0; i < 32; i++)
        regs[i] <= '0;
    end else if (RegWriteIn && WriteReg != 5'd31) begin
      regs[WriteReg] <= WriteData;
    end
  end

  // Reads are gated so XZR and in-reset reads are zero independent of array contents.
  assign rn        = Instruction[9:5];
  assign rsel2     = Reg2Loc ? Instruction[4:0] : Instruction[20:16];
  assign ReadData1 = (!Reset_n || rn == 5'd31) ? '0 : regs[rn];
  assign ReadData2 = (!Reset_n || rsel2 == 5'd31) ? '0 : regs[rsel2];

  assign taken = (iclass == I_B)
              || (iclass == I_CBZ  && ReadData2 == '0)
              || (iclass == I_CBNZ && ReadData2 != '0);
  assign PCSrc         = Reset_n && taken;
  assign BranchAddress = PC + (SignExtImm << 2);

endmodule

// File: tb/tb_instruction_decode.sv
// Bench for instruction_decode: directed scenarios with literal expectations, then
// randomized instructions/write-backs compared every cycle against a mnemonic-level model.
module tb_instruction_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic [63:0] pc;
  logic        pcsrc;
  logic [63:0] baddr;
  logic        we;
  logic [4:0]  wreg;
  logic [63:0] wdata;
  logic [63:0] rd1, rd2, imm;
  logic        reg2loc, alusrc, memtoreg, regwrite, memread, memwrite, branch;
  logic [1:0]  aluop;

  int checks = 0;
  int errors = 0;

  logic [63:0] mreg [32];

  typedef struct {
    logic        pcsrc;
    logic [63:0] baddr;
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic [63:0] imm;
    logic [8:0]  ctl;
  } exp_t;

  instruction_decode dut (
    .Instruction(instr), .PC(pc), .PCSrc(pcsrc), .BranchAddress(baddr),
    .Clk(clk), .Reset_n(rst_n), .RegWriteIn(we), .WriteReg(wreg), .WriteData(wdata),
    .ReadData1(rd1), .ReadData2(rd2), .SignExtImm(imm),
    .Reg2Loc(reg2loc), .ALUSrc(alusrc), .MemtoReg(memtoreg), .RegWrite(regwrite),
    .MemRead(memread), .MemWrite(memwrite), .Branch(branch), .ALUOp(aluop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference register file: XZR is never stored, reset clears everything.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mreg[i] <= '0;
    end else if (we && wreg != 5'd31) begin
      mreg[wreg] <= wdata;
    end
  end

  function automatic logic [63:0] rdreg(input logic [4:0] a, input logic live);
    return (live && a != 5'd31) ? mreg[a] : 64'd0;
  endfunction

  // ctl packs {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp}
  function automatic exp_t model(input logic [31:0] ins, input logic [63:0] p, input logic live);
    exp_t  e;
    string mn;
    int    op11, op10, op8, op6;
    op11 = int'(ins[31:21]);
    op10 = int'(ins[31:22]);
    op8  = int'(ins[31:24]);
    op6  = int'(ins[31:26]);
    if      (op11 == 'h458 || op11 == 'h658 || op11 == 'h450 || op11 == 'h550) mn = "RTYPE";
    else if (op10 == 'h244 || op10 == 'h344) mn = "ADDI";
    else if (op11 == 'h7C2) mn = "LDUR";
    else if (op11 == 'h7C0) mn = "STUR";
    else if (op6  == 5)     mn = "B";
    else if (op8  == 'hB4)  mn = "CBZ";
    else if (op8  == 'hB5)  mn = "CBNZ";
    else                    mn = "NONE";
    e.imm = 64'd0;
    case (mn)
      "RTYPE": e.ctl = 9'b0001_000_10;
      "ADDI":  begin e.ctl = 9'b0101_000_10; e.imm = 64'(ins[21:10]); end
      "LDUR":  begin e.ctl = 9'b0111_100_00; e.imm = 64'($signed(ins[20:12])); end
      "STUR":  begin e.ctl = 9'b1100_010_00; e.imm = 64'($signed(ins[20:12])); end
      "B":     begin e.ctl = 9'b0000_001_00; e.imm = 64'($signed(ins[25:0])); end
      "CBZ", "CBNZ": begin e.ctl = 9'b1000_001_01; e.imm = 64'($signed(ins[23:5])); end
      default: e.ctl = 9'd0;
    endcase
    e.rd1   = rdreg(ins[9:5], live);
    e.rd2   = rdreg(e.ctl[8] ? ins[4:0] : ins[20:16], live);
    e.pcsrc = live && (mn == "B" || (mn == "CBZ" && e.rd2 == 0) || (mn == "CBNZ" && e.rd2 != 0));
    e.baddr = p + e.imm * 64'd4;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    e = model(instr, pc, rst_n);
    chk("PCSrc", 64'(pcsrc), 64'(e.pcsrc));
    chk("BranchAddress", baddr, e.baddr);
    chk("ReadData1", rd1, e.rd1);
    chk("ReadData2", rd2, e.rd2);
    chk("SignExtImm", imm, e.imm);
    chk("controls", 64'({reg2loc, alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop}),
        64'(e.ctl));
  end

  task automatic apply(input logic [31:0] ins, input logic [63:0] p);
    @(posedge clk);
    #1 instr = ins; pc = p;
    #2;
  endtask

  task automatic wb(input logic [4:0] r, input logic [63:0] d);
    @(posedge clk);
    #1 we = 1'b1; wreg = r; wdata = d;
    @(posedge clk);
    #1 we = 1'b0;
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    logic [10:0] rops [4];
    rops = '{11'h458, 11'h658, 11'h450, 11'h550};
    r = $urandom;
    r[4:0]   = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
    r[9:5]   = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
    case ($urandom_range(0, 8))
      0: begin r[31:21] = rops[$urandom_range(0, 3)]; r[20:16] = 5'($urandom_range(0, 7)); end
      1: r[31:22] = ($urandom_range(0, 1) == 1) ? 10'b1001000100 : 10'b1101000100;
      2: r[31:21] = 11'b11111000010;
      3: r[31:21] = 11'b11111000000;
      4: r[31:26] = 6'b000101;
      5: r[31:24] = 8'b10110100;
      6: r[31:24] = 8'b10110101;
      7: r[31:21] = '1;
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    rst_n = 1'b1;
    instr = '0; pc = '0; we = 1'b0; wreg = '0; wdata = '0;
    #1 rst_n = 1'b0;
    instr = {8'b10110101, 19'd2, 5'd1};
    pc    = 64'h100;
    #3 chk("reset_pcsrc", 64'(pcsrc), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #2 chk("post_reset_rd2", rd2, 64'd0);
    chk("post_reset_pcsrc", 64'(pcsrc), 64'd0);

    apply({6'b000101, 26'h3FFFFFF}, 64'h40);
    chk("b_pcsrc", 64'(pcsrc), 64'd1);
    chk("b_target", baddr, 64'h3C);

    wb(5'd2, 64'd0);
    apply({8'b10110100, 19'd3, 5'd2}, 64'h20);
    chk("cbz_zero_pcsrc", 64'(pcsrc), 64'd1);
    chk("cbz_target", baddr, 64'h2C);

    wb(5'd2, 64'd5);
    apply({8'b10110100, 19'd3, 5'd2}, 64'h20);
    chk("cbz_nonzero_pcsrc", 64'(pcsrc), 64'd0);
    apply({8'b10110101, 19'd3, 5'd2}, 64'h20);
    chk("cbnz_nonzero_pcsrc", 64'(pcsrc), 64'd1);
    chk("cbnz_rd2", rd2, 64'd5);

    apply({11'b11111000010, 9'h1F8, 2'b00, 5'd4, 5'd3}, 64'h0);
    chk("ldur_controls", 64'({reg2loc, alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop}),
        64'(9'b011110000));
    chk("ldur_imm", imm, 64'hFFFF_FFFF_FFFF_FFF8);

    wb(5'd31, 64'h55);
    apply({11'h458, 5'd0, 6'd0, 5'd31, 5'd0}, 64'h0);
    chk("xzr_rd1", rd1, 64'd0);

    apply(32'hFFE0_0000, 64'h80);
    chk("halt_controls", 64'({reg2loc, alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop}),
        64'd0);
    chk("halt_pcsrc", 64'(pcsrc), 64'd0);
    chk("halt_imm", imm, 64'd0);

    for (int c = 0; c < 2000; c++) begin
      @(posedge clk);
      #1;
      instr = gen_instr();
      pc    = {$urandom, $urandom};
      we    = ($urandom_range(0, 2) != 0);
      wreg  = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      wdata = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
      rst_n = !(c % 250 == 100);
    end
    @(posedge clk);
    #1 rst_n = 1'b1; we = 1'b0;
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
